// File: rtl/hwag_cfg_seq.sv
// Register-bank configuration sequencer: copies a default table from ROM into the
// register bank, reads every register back to verify it, then opens the bank to host accesses.
// Latency: start to done is 4*N+1 cycles, counting the start-sampling edge as cycle 1 (N = LAST_ADDR+1).
// Backpressure: the host is stalled (host_gnt=0) outside READY and must hold host_req until granted.
// Ports:
//   clk, rst                 clock, async active-high reset
//   start                    one-cycle request to run load+verify (ignored while busy)
//   rom_addr / rom_data      default table; data valid one cycle after address
//   reg_addr/reg_wdata/reg_we/reg_re/reg_rdata  register bank; rdata valid one cycle after reg_re
//   host_req/host_we/host_addr/host_wdata/host_gnt  host access, granted in READY only
//   host_rvalid/host_rdata   host read return, one cycle after a granted read
//   busy/done/err/err_addr   status; err_addr holds the first mismatching address of a run
module hwag_cfg_seq #(
  parameter int LAST_ADDR = 130,
  parameter int AW        = 8,
  parameter int DW        = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_data,
  output logic [AW-1:0] reg_addr,
  output logic [DW-1:0] reg_wdata,
  output logic          reg_we,
  output logic          reg_re,
  input  logic [DW-1:0] reg_rdata,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_gnt,
  output logic          host_rvalid,
  output logic [DW-1:0] host_rdata,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] err_addr
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    WRITE  = 3'd2,
    VREAD  = 3'd3,
    VCHECK = 3'd4,
    READY  = 3'd5
  } state_t;

  localparam logic [AW-1:0] LAST = AW'(LAST_ADDR);

  state_t        state;
  logic [AW-1:0] a;
  logic          host_acc;

  // start wins over a simultaneous host request in READY
  assign host_acc = (state == READY) && host_req && !start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      a           <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
      err_addr    <= '0;
      host_rvalid <= 1'b0;
    end else begin
      host_rvalid <= host_acc && !host_we;
      case (state)
        IDLE, READY: begin
          if (start) begin
            a        <= '0;
            err      <= 1'b0;
            err_addr <= '0;
            done     <= 1'b0;
            state    <= FETCH;
          end
        end
        FETCH: state <= WRITE;
        WRITE: begin
          if (a == LAST) begin
            a     <= '0;
            state <= VREAD;
          end else begin
            a     <= a + 1'b1;
            state <= FETCH;
          end
        end
        VREAD: state <= VCHECK;
        VCHECK: begin
          // only the first mismatch of a run is recorded
          if ((rom_data != reg_rdata) && !err) begin
            err      <= 1'b1;
            err_addr <= a;
          end
          if (a == LAST) begin
            done  <= 1'b1;
            state <= READY;
          end else begin
            a     <= a + 1'b1;
            state <= VREAD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Bank/ROM strobes decode straight from the state register so that
  // rom_data and reg_rdata line up with WRITE and VCHECK one cycle later.
  always_comb begin
    rom_addr  = '0;
    reg_addr  = '0;
    reg_wdata = '0;
    reg_we    = 1'b0;
    reg_re    = 1'b0;
    host_gnt  = 1'b0;
    busy      = 1'b0;
    case (state)
      FETCH: begin
        busy     = 1'b1;
        rom_addr = a;
      end
      WRITE: begin
        busy      = 1'b1;
        reg_we    = 1'b1;
        reg_addr  = a;
        reg_wdata = rom_data;
      end
      VREAD: begin
        busy     = 1'b1;
        rom_addr = a;
        reg_re   = 1'b1;
        reg_addr = a;
      end
      VCHECK: busy = 1'b1;
      READY: begin
        if (host_acc) begin
          host_gnt = 1'b1;
          reg_addr = host_addr;
          reg_we   = host_we;
          reg_re   = !host_we;
          // write data only travels with a write strobe
          if (host_we) reg_wdata = host_wdata;
        end
      end
      default: ;
    endcase
  end

  assign host_rdata = host_rvalid ? reg_rdata : '0;

endmodule

// File: tb/tb_hwag_cfg_seq.sv
module tb_hwag_cfg_seq;
  localparam int LAST = 130;
  localparam int N    = LAST + 1;
  localparam int LAT  = 4 * N + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  rom_addr;
  logic [15:0] rom_data;
  logic [7:0]  reg_addr;
  logic [15:0] reg_wdata;
  logic        reg_we, reg_re;
  logic [15:0] reg_rdata;
  logic        host_req = 1'b0, host_we = 1'b0;
  logic [7:0]  host_addr = '0;
  logic [15:0] host_wdata = '0;
  logic        host_gnt, host_rvalid;
  logic [15:0] host_rdata;
  logic        busy, done, err;
  logic [7:0]  err_addr;

  int checks = 0;
  int failures = 0;

  hwag_cfg_seq dut (
    .clk(clk), .rst(rst), .start(start),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
    .reg_rdata(reg_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .busy(busy), .done(done), .err(err), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  // ROM and register-bank models
  logic [15:0] rom_mem  [0:255];
  logic [15:0] bank_mem [0:255];
  int          c1_addr = 999, c2_addr = 999;
  logic [15:0] c1_val = '0, c2_val = '0;
  int          wr_addr_q[$];
  logic [15:0] wr_data_q[$];
  int          inv_viol = 0;
  int          gnt_busy_cnt = 0;

  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  always @(posedge clk) begin
    if (reg_we) begin
      wr_addr_q.push_back(int'(reg_addr));
      wr_data_q.push_back(reg_wdata);
      if (int'(reg_addr) == c1_addr)      bank_mem[reg_addr] <= c1_val;
      else if (int'(reg_addr) == c2_addr) bank_mem[reg_addr] <= c2_val;
      else                                bank_mem[reg_addr] <= reg_wdata;
    end
    if (reg_re) reg_rdata <= bank_mem[reg_addr];
  end

  always @(negedge clk) begin
    if (reg_we && reg_re) inv_viol++;
    if (!reg_we && !reg_re && (reg_addr != 0 || reg_wdata != 0)) inv_viol++;
    if (busy && host_gnt) gnt_busy_cnt++;
  end

  // value the bank ends up holding after a load of address i
  function automatic logic [15:0] stored(input int i);
    if (i == c1_addr) return c1_val;
    if (i == c2_addr) return c2_val;
    return rom_mem[i];
  endfunction

  function automatic int first_bad();
    for (int i = 0; i <= LAST; i++)
      if (stored(i) != rom_mem[i]) return i;
    return -1;
  endfunction

  task automatic spec_rom();
    for (int i = 0; i < 256; i++) rom_mem[i] = '0;
    rom_mem[4] = 16'd57; rom_mem[5] = 16'd4; rom_mem[6] = 16'd3839; rom_mem[129] = 16'd3830;
  endtask

  task automatic random_rom();
    for (int i = 0; i < 256; i++) rom_mem[i] = 16'($urandom_range(0, 65535));
  endtask

  task automatic run_seq(input bit noisy, output int lat);
    wr_addr_q.delete(); wr_data_q.delete();
    gnt_busy_cnt = 0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); lat = 1; #1 start = 1'b0;
    while (done !== 1'b1 && lat < 3000) begin
      @(posedge clk); lat++; #1;
      start = noisy && (lat < 500) && (lat % 37 == 0);
    end
    start = 1'b0;
  endtask

  task automatic check_writes(input string name);
    int bad = -1;
    if (wr_addr_q.size() != N) bad = 9999;
    else for (int i = 0; i < N; i++)
      if (bad < 0 && (wr_addr_q[i] != i || wr_data_q[i] !== rom_mem[i])) bad = i;
    checks++;
    if (bad >= 0) begin
      failures++;
      $display("FAIL %s write_order: writes=%0d first_bad_index=%0d required %0d in-order writes", name, wr_addr_q.size(), bad, N);
    end
  endtask

  task automatic test_reset();
    start = 1'b1; host_req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({rom_addr, reg_addr, reg_wdata, reg_we, reg_re, host_gnt, host_rvalid, host_rdata,
         busy, done, err, err_addr} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: busy=%b done=%b gnt=%b we=%b re=%b required all 0", busy, done, host_gnt, reg_we, reg_re);
    end
    start = 1'b0;
    @(negedge clk); rst = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || host_gnt !== 1'b0 || reg_we !== 1'b0) begin
      failures++;
      $display("FAIL idle_needs_start: busy=%b gnt=%b we=%b required 0 0 0", busy, host_gnt, reg_we);
    end
    host_req = 1'b0;
  endtask

  task automatic test_load_verify();
    int lat;
    spec_rom(); c1_addr = 999; c2_addr = 999;
    run_seq(1'b0, lat);
    checks++;
    if (lat != LAT) begin failures++; $display("FAIL load_latency: got %0d required %0d", lat, LAT); end
    check_writes("load");
    checks++;
    if (bank_mem[4] !== 16'd57 || bank_mem[129] !== 16'd3830) begin
      failures++; $display("FAIL bank_content: addr4=%0d addr129=%0d required 57 3830", bank_mem[4], bank_mem[129]);
    end
    checks++;
    if (err !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL load_status: err=%b done=%b busy=%b required 0 1 0", err, done, busy);
    end
  endtask

  task automatic test_host_hold();
    int lat;
    @(negedge clk); host_req = 1'b1; host_we = 1'b0; host_addr = 8'd6;
    run_seq(1'b0, lat);
    checks++;
    if (gnt_busy_cnt != 0) begin failures++; $display("FAIL gnt_while_busy: got %0d grants required 0", gnt_busy_cnt); end
    checks++;
    if (host_gnt !== 1'b1) begin failures++; $display("FAIL gnt_first_ready: got %b required 1", host_gnt); end
    @(posedge clk); #1;
    checks++;
    if (host_rvalid !== 1'b1 || host_rdata !== 16'd3839) begin
      failures++; $display("FAIL host_read6: rvalid=%b rdata=%0d required 1 3839", host_rvalid, host_rdata);
    end
    @(negedge clk); host_req = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (host_rvalid !== 1'b0) begin failures++; $display("FAIL rvalid_pulse: got %b required 0", host_rvalid); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] model [0:LAST];
    bit   rd;
    int   ad;
    for (int i = 0; i <= LAST; i++) model[i] = rom_mem[i];
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      rd = ($urandom_range(0, 1) == 1);
      ad = $urandom_range(0, LAST);
      host_req = 1'b1; host_we = !rd; host_addr = 8'(ad);
      host_wdata = 16'($urandom_range(0, 65535));
      #1;
      checks++;
      if (host_gnt !== 1'b1) begin failures++; $display("FAIL b2b_gnt[%0d]: got %b required 1", k, host_gnt); end
      @(posedge clk); #1;
      checks++;
      if (rd && (host_rvalid !== 1'b1 || host_rdata !== model[ad])) begin
        failures++; $display("FAIL b2b_read[%0d]: addr=%0d rvalid=%b rdata=%0d required 1 %0d", k, ad, host_rvalid, host_rdata, model[ad]);
      end else if (!rd && host_rvalid !== 1'b0) begin
        failures++; $display("FAIL b2b_write_rvalid[%0d]: got %b required 0", k, host_rvalid);
      end
      if (!rd) model[ad] = host_wdata;
    end
    @(negedge clk); host_req = 1'b0; host_we = 1'b0;
  endtask

  task automatic test_start_priority();
    int cyc = 0;
    @(negedge clk); host_req = 1'b1; host_we = 1'b0; host_addr = 8'd4; start = 1'b1;
    #1;
    checks++;
    if (host_gnt !== 1'b0) begin failures++; $display("FAIL start_priority_gnt: got %b required 0", host_gnt); end
    @(posedge clk); #1; start = 1'b0; host_req = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || host_rvalid !== 1'b0) begin
      failures++; $display("FAIL start_priority_state: busy=%b done=%b rvalid=%b required 1 0 0", busy, done, host_rvalid);
    end
    while (done !== 1'b1 && cyc < 3000) begin @(posedge clk); cyc++; #1; end
    checks++;
    if (done !== 1'b1) begin failures++; $display("FAIL start_priority_finish: done=%b after %0d cycles required 1", done, cyc); end
  endtask

  task automatic test_corrupt();
    int lat;
    random_rom();
    rom_mem[70] = 16'd2; c1_addr = 70; c1_val = 16'd5;
    c2_addr = 100; c2_val = rom_mem[100] ^ 16'h0101;
    run_seq(1'b0, lat);
    checks++;
    if (lat != LAT) begin failures++; $display("FAIL corrupt_latency: got %0d required %0d", lat, LAT); end
    check_writes("corrupt");
    checks++;
    if (err !== 1'b1 || err_addr !== 8'd70 || done !== 1'b1) begin
      failures++; $display("FAIL corrupt_err: err=%b err_addr=%0d done=%b required 1 70 1", err, err_addr, done);
    end
  endtask

  task automatic test_random_corrupt();
    int lat, exp_a;
    for (int r = 0; r < 2; r++) begin
      random_rom();
      c1_addr = $urandom_range(0, LAST); c1_val = rom_mem[c1_addr] + 16'd1;
      c2_addr = $urandom_range(0, LAST); c2_val = rom_mem[c2_addr] ^ 16'h8000;
      exp_a = first_bad();
      run_seq(1'b0, lat);
      checks++;
      if (err !== 1'b1 || int'(err_addr) != exp_a || lat != LAT) begin
        failures++; $display("FAIL rand_corrupt[%0d]: err=%b err_addr=%0d lat=%0d required 1 %0d %0d", r, err, err_addr, lat, exp_a, LAT);
      end
    end
    c1_addr = 999; c2_addr = 999;
  endtask

  task automatic test_reset_mid();
    int lat, cyc = 0;
    random_rom();
    wr_addr_q.delete(); wr_data_q.delete();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    while (!(reg_we === 1'b1 && reg_addr == 8'd60) && cyc < 3000) begin @(negedge clk); cyc++; end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({rom_addr, reg_addr, reg_wdata, reg_we, reg_re, host_gnt, host_rvalid, host_rdata,
         busy, done, err, err_addr} !== '0) begin
      failures++; $display("FAIL mid_reset_outputs: busy=%b we=%b addr=%0d required all 0", busy, reg_we, reg_addr);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (wr_addr_q.size() != 60 || busy !== 1'b0) begin
      failures++; $display("FAIL mid_reset_abort: writes=%0d busy=%b required 60 0", wr_addr_q.size(), busy);
    end
    run_seq(1'b1, lat);
    checks++;
    if (lat != LAT) begin failures++; $display("FAIL noisy_start_latency: got %0d required %0d", lat, LAT); end
    check_writes("after_reset");
    checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL after_reset_err: got %b required 0", err); end
  endtask

  task automatic test_invariants();
    checks++;
    if (inv_viol != 0) begin failures++; $display("FAIL strobe_invariants: violations=%0d required 0", inv_viol); end
  endtask

  initial begin
    test_reset();
    test_load_verify();
    test_host_hold();
    test_back_to_back();
    test_start_priority();
    test_corrupt();
    test_random_corrupt();
    test_reset_mid();
    test_invariants();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
